// File: rtl/ifm_addr_gen_strided.sv
// IFM read-address generator: walks a whole convolution layer (tiles, output rows,
// channels, kernel rows/cols) from one start pulse, with stride and valid/ready flow.
module ifm_addr_gen_strided #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned KERNEL_SIZE   = 3,
    parameter int unsigned STRIDE        = 1,
    parameter int unsigned IFM_SIZE      = 34,
    parameter int unsigned IFM_CHANNEL   = 3,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned SIZE_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] ifm_addr,
    output logic [SIZE_WIDTH-1:0] size,
    output logic                  win_last,
    output logic                  tile_last
);
    localparam int unsigned OFM_SIZE   = (IFM_SIZE - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned NUM_TILES  = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int unsigned WIN_LEN    = IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned LAST_SIZE  = OFM_SIZE - (NUM_TILES - 1) * SYSTOLIC_SIZE;
    localparam int unsigned FIRST_SIZE = (NUM_TILES == 1) ? LAST_SIZE : SYSTOLIC_SIZE;

    localparam int unsigned KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned CW = (IFM_CHANNEL > 1) ? $clog2(IFM_CHANNEL) : 1;
    localparam int unsigned RW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IFM_CHANNEL - 1);
    localparam logic [RW-1:0] R_LAST = RW'(OFM_SIZE - 1);
    localparam logic [TW-1:0] T_LAST = TW'(NUM_TILES - 1);

    localparam logic [ADDR_WIDTH-1:0] KY_STEP   = ADDR_WIDTH'(IFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] CH_STEP   = ADDR_WIDTH'(IFM_SIZE * IFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(STRIDE * IFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE * STRIDE);

    localparam logic [SIZE_WIDTH-1:0] SZ_FULL  = SIZE_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [SIZE_WIDTH-1:0] SZ_LAST  = SIZE_WIDTH'(LAST_SIZE);
    localparam logic [SIZE_WIDTH-1:0] SZ_FIRST = SIZE_WIDTH'(FIRST_SIZE);

    localparam logic FIRST_WIN_LAST  = (WIN_LEN == 1);
    localparam logic FIRST_TILE_LAST = (WIN_LEN == 1) && (OFM_SIZE == 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]            state, state_nx;
    logic [KW-1:0]         kx, ky, nx_kx, nx_ky;
    logic [CW-1:0]         c, nx_c;
    logic [RW-1:0]         r, nx_r;
    logic [TW-1:0]         t, nx_t;
    logic [ADDR_WIDTH-1:0] ky_base, ch_base, row_base, tile_base;
    logic [ADDR_WIDTH-1:0] nx_ky_base, nx_ch_base, nx_row_base, nx_tile_base, nx_addr;
    logic                  nx_win_last, nx_tile_last;
    logic                  fire_c, last_addr_c;

    assign fire_c = addr_valid & addr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_RUN;
            S_RUN:    if (fire_c && last_addr_c) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Nested-loop advance: each wrapping level reloads all inner base pointers
    always_comb begin
        nx_kx        = kx;
        nx_ky        = ky;
        nx_c         = c;
        nx_r         = r;
        nx_t         = t;
        nx_ky_base   = ky_base;
        nx_ch_base   = ch_base;
        nx_row_base  = row_base;
        nx_tile_base = tile_base;
        nx_addr      = ifm_addr;
        last_addr_c  = 1'b0;
        if (kx != K_LAST) begin
            nx_kx   = kx + KW'(1);
            nx_addr = ifm_addr + ADDR_WIDTH'(1);
        end else if (ky != K_LAST) begin
            nx_kx      = '0;
            nx_ky      = ky + KW'(1);
            nx_ky_base = ky_base + KY_STEP;
            nx_addr    = ky_base + KY_STEP;
        end else if (c != C_LAST) begin
            nx_kx      = '0;
            nx_ky      = '0;
            nx_c       = c + CW'(1);
            nx_ch_base = ch_base + CH_STEP;
            nx_ky_base = ch_base + CH_STEP;
            nx_addr    = ch_base + CH_STEP;
        end else if (r != R_LAST) begin
            nx_kx       = '0;
            nx_ky       = '0;
            nx_c        = '0;
            nx_r        = r + RW'(1);
            nx_row_base = row_base + ROW_STEP;
            nx_ch_base  = row_base + ROW_STEP;
            nx_ky_base  = row_base + ROW_STEP;
            nx_addr     = row_base + ROW_STEP;
        end else if (t != T_LAST) begin
            nx_kx        = '0;
            nx_ky        = '0;
            nx_c         = '0;
            nx_r         = '0;
            nx_t         = t + TW'(1);
            nx_tile_base = tile_base + TILE_STEP;
            nx_row_base  = tile_base + TILE_STEP;
            nx_ch_base   = tile_base + TILE_STEP;
            nx_ky_base   = tile_base + TILE_STEP;
            nx_addr      = tile_base + TILE_STEP;
        end else begin
            last_addr_c = 1'b1;
        end
        nx_win_last  = (nx_kx == K_LAST) && (nx_ky == K_LAST) && (nx_c == C_LAST);
        nx_tile_last = nx_win_last && (nx_r == R_LAST);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_valid <= 1'b0;
            ifm_addr   <= '0;
            size       <= SZ_FULL;
            win_last   <= 1'b0;
            tile_last  <= 1'b0;
            kx         <= '0;
            ky         <= '0;
            c          <= '0;
            r          <= '0;
            t          <= '0;
            ky_base    <= '0;
            ch_base    <= '0;
            row_base   <= '0;
            tile_base  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        addr_valid <= 1'b1;
                        ifm_addr   <= '0;
                        size       <= SZ_FIRST;
                        win_last   <= FIRST_WIN_LAST;
                        tile_last  <= FIRST_TILE_LAST;
                        kx         <= '0;
                        ky         <= '0;
                        c          <= '0;
                        r          <= '0;
                        t          <= '0;
                        ky_base    <= '0;
                        ch_base    <= '0;
                        row_base   <= '0;
                        tile_base  <= '0;
                    end
                end
                S_RUN: begin
                    if (fire_c) begin
                        if (last_addr_c) begin
                            addr_valid <= 1'b0;
                            done       <= 1'b1;
                            win_last   <= 1'b0;
                            tile_last  <= 1'b0;
                        end else begin
                            kx        <= nx_kx;
                            ky        <= nx_ky;
                            c         <= nx_c;
                            r         <= nx_r;
                            t         <= nx_t;
                            ky_base   <= nx_ky_base;
                            ch_base   <= nx_ch_base;
                            row_base  <= nx_row_base;
                            tile_base <= nx_tile_base;
                            ifm_addr  <= nx_addr;
                            win_last  <= nx_win_last;
                            tile_last <= nx_tile_last;
                            size      <= (nx_t == T_LAST) ? SZ_LAST : SZ_FULL;
                        end
                    end
                end
                S_FINISH: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
